// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared level-grid constants, cell codes and spawner state encoding
package grid_pkg;
  localparam int GRID_W = 40;
  localparam int GRID_H = 30;
  localparam int X_W    = 6;
  localparam int Y_W    = 5;

  localparam logic [2:0] CELL_AIR   = 3'd0;
  localparam logic [2:0] CELL_ENEMY = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EVAL,
    ST_PICK,
    ST_PROBE,
    ST_WRITE,
    ST_DONE
  } spawn_state_t;
endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR, taps 16,14,13,11
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state
);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= SEED;
    else        state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
  end
endmodule

// File: rtl/enemy_spawner.sv
// rtl/enemy_spawner.sv - counts live enemies on the grid and spawns one on a random air cell
// Optional macro SPAWN_GUARD_EN widens the player keep-out from one cell to a 5x5 square.
module enemy_spawner
  import grid_pkg::*;
#(
  parameter int          MAX_ENEMIES = 8,
  parameter int          MAX_TRIES   = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic             spawned,
  output logic [3:0]       enemy_count,
  input  logic [X_W-1:0]   player_x,
  input  logic [Y_W-1:0]   player_y,
  output logic [X_W-1:0]   grid_x,
  output logic [Y_W-1:0]   grid_y,
  input  logic [2:0]       grid_out,
  output logic             grid_write,
  output logic [2:0]       grid_in
);
  localparam logic [X_W-1:0] LAST_X   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] LAST_Y   = Y_W'(GRID_H - 1);
  localparam logic [3:0]     CAP      = 4'(MAX_ENEMIES);
  localparam logic [4:0]     TRY_LIM  = 5'(MAX_TRIES);

  spawn_state_t   state;
  logic [4:0]     tries;
  logic [15:0]    lfsr;
  logic [X_W-1:0] pick_x;
  logic [Y_W-1:0] pick_y;
  logic           near_player;
  logic           reject;
  logic           unused_lfsr_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .state (lfsr)
  );

  assign pick_x           = lfsr[5:0];
  assign pick_y           = lfsr[12:8];
  assign unused_lfsr_bits = ^{lfsr[15:13], lfsr[7:6]};

`ifdef SPAWN_GUARD_EN
  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;
  assign dx          = (pick_x >= player_x) ? pick_x - player_x : player_x - pick_x;
  assign dy          = (pick_y >= player_y) ? pick_y - player_y : player_y - pick_y;
  assign near_player = (dx <= X_W'(2)) && (dy <= Y_W'(2));
`else
  assign near_player = (pick_x == player_x) && (pick_y == player_y);
`endif

  assign reject = (pick_x > LAST_X) || (pick_y > LAST_Y) || near_player;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      done        <= 1'b0;
      spawned     <= 1'b0;
      enemy_count <= 4'd0;
      grid_x      <= '0;
      grid_y      <= '0;
      grid_write  <= 1'b0;
      grid_in     <= CELL_AIR;
      tries       <= 5'd0;
    end else begin
      done       <= 1'b0;
      grid_write <= 1'b0;
      grid_in    <= CELL_AIR;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_SCAN;
            grid_x      <= '0;
            grid_y      <= '0;
            enemy_count <= 4'd0;
            spawned     <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (grid_out == CELL_ENEMY && enemy_count < CAP)
            enemy_count <= enemy_count + 4'd1;
          if (grid_x == LAST_X) begin
            grid_x <= '0;
            if (grid_y == LAST_Y) state  <= ST_EVAL;
            else                  grid_y <= grid_y + Y_W'(1);
          end else begin
            grid_x <= grid_x + X_W'(1);
          end
        end
        ST_EVAL: begin
          if (enemy_count >= CAP) begin
            state <= ST_DONE;
          end else begin
            tries <= 5'd0;
            state <= ST_PICK;
          end
        end
        ST_PICK: begin
          tries <= tries + 5'd1;
          if (reject) begin
            if (tries + 5'd1 == TRY_LIM) state <= ST_DONE;
          end else begin
            // grid_x/grid_y double as the latched candidate for PROBE and WRITE
            grid_x <= pick_x;
            grid_y <= pick_y;
            state  <= ST_PROBE;
          end
        end
        ST_PROBE: begin
          if (grid_out == CELL_AIR) begin
            grid_write <= 1'b1;
            grid_in    <= CELL_ENEMY;
            state      <= ST_WRITE;
          end else if (tries == TRY_LIM) begin
            state <= ST_DONE;
          end else begin
            state <= ST_PICK;
          end
        end
        ST_WRITE: begin
          spawned <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
